dram_cmd_sched: RTL and testbench
=================================

Name: dram_cmd_sched

Overview:
- Downstream stage of dram_ctrl. Consumes its cmd_req/cmd/bank/row/col 4-phase handshake and returns cmd_ack.
- Converts each request into ordered DRAM primitives (precharge, activate, column access) against the dram_bfm array/row-buffer model.
- Tracks the open row per bank (open-page policy) and enforces tRP/tRCD/tCAS with down-counters.
- Read data is returned alongside cmd_ack.

Parameters:
- NUM_OF_BANKS, 8, number of banks; BANK_W = $clog2(NUM_OF_BANKS).
- NUM_OF_ROWS, 128, rows per bank; ROW_W = $clog2(NUM_OF_ROWS).
- NUM_OF_COLS, 8, columns per row; COL_W = $clog2(NUM_OF_COLS).
- DATA_WIDTH, 8, data word width.
- T_RP, 2, precharge cycles (≥1).
- T_RCD, 3, activate-to-access cycles (≥1).
- T_CAS, 2, access cycles (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_req  in  1  request, held until cmd_ack seen high.
- cmd  in  2  00 NOP, 01 READ, 10 WRITE, 11 PRECHARGE_ALL.
- bank_id  in  BANK_W  target bank.
- row_id  in  ROW_W  target row.
- col_id  in  COL_W  target column.
- wr_data  in  DATA_WIDTH  write data.
- cmd_ack  out  1  completion acknowledge.
- rd_data  out  DATA_WIDTH  read data, valid while cmd_ack=1 for READ.
- dram_pre  out  1  one-cycle strobe: write row buffer back to array.
- dram_act  out  1  one-cycle strobe: load row into row buffer.
- dram_buf_en  out  1  column access strobe.
- dram_buf_rw  out  1  1 = write buffer, 0 = read.
- dram_bank_id  out  BANK_W  bank for the primitive.
- dram_row_id  out  ROW_W  row for the primitive.
- dram_col_id  out  COL_W  column for the primitive.
- dram_din  out  DATA_WIDTH  write data to buffer.
- dram_dout  in  DATA_WIDTH  read data from buffer.

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; open_valid[*]=0; open_row[*]=0; timer=0.
- States: IDLE, PRE, ACT, ACCESS, ACK, PRE_ALL.
- IDLE, on cmd_req=1 with cmd_ack=0:
  - Latch cmd, ids and wr_data.
  - READ/WRITE, row hit (open_valid[b] && open_row[b]==row): go to ACCESS.
  - READ/WRITE, bank closed: go to ACT.
  - READ/WRITE, row miss: go to PRE.
  - NOP: go directly to ACK.
  - PRECHARGE_ALL: go to PRE_ALL.
- PRE:
  - dram_pre pulses in the entry cycle; timer loads T_RP-1.
  - Exit to ACT when timer==0; clear open_valid[b].
- ACT:
  - dram_act pulses in the entry cycle; timer loads T_RCD-1.
  - At exit set open_valid[b]=1, open_row[b]=row; go to ACCESS.
- ACCESS:
  - dram_buf_en=1 for T_CAS cycles; dram_buf_rw reflects cmd.
  - READ: rd_data captured from dram_dout in the last cycle.
  - Then go to ACK.
- PRE_ALL:
  - Iterates banks 0..NUM_OF_BANKS-1, one per T_RP window.
  - Pulses dram_pre only for banks with open_valid=1; closed banks take 1 cycle each.
  - Clears all open_valid, then goes to ACK.
- ACK:
  - cmd_ack=1 and held; rd_data stable.
  - When cmd_req falls: cmd_ack=0 next cycle, go to IDLE.
  - No new request is accepted until cmd_ack has returned low (full 4-phase).
- Latency, cycles from cmd_req rise to cmd_ack rise:
  - hit = 1 + T_CAS.
  - closed = 1 + T_RCD + T_CAS.
  - miss = 1 + T_RP + T_RCD + T_CAS.
- dram_* id outputs hold latched values outside strobes; they do not return to 0.
- Inputs are sampled only at IDLE acceptance. Changes during service are ignored.
- cmd_req dropping before ack is a protocol violation. The block completes the operation and then proceeds with ACK, so ack is not missed.
- rst mid-operation: immediate return to IDLE with all open rows forgotten. Data in the BFM buffer is not written back.

Optional Feature:
- DRAM_SCHED_STATS_EN:
  - Adds 16-bit saturating outputs stat_hits, stat_misses, stat_closed.
  - Each counter increments once per READ/WRITE at IDLE acceptance; reset to 0.
- Without the macro: the ports do not exist and no counter logic is built.

Decomposition:
- dram_pkg:
  - cmd encoding localparams (CMD_NOP/READ/WRITE/PREALL).
  - sched_state_t enum.
  - Default timing localparams.
- One sub-module: dram_open_row_table. Per-bank valid/row registers with a lookup port returning hit/closed/miss, plus update/clear/clear_all ports.

Test Plan:
- WRITE bank2 row5 col3 data 0xA5 from reset → dram_act then dram_buf_en/rw=1; cmd_ack 1+3+2=6 cycles after req; open_row[2]=5.
- READ bank2 row5 col3 after it → no pre/act; ack 3 cycles after req; rd_data=0xA5.
- READ bank2 row9 → dram_pre, dram_act, access in order; ack after 8 cycles; rd_data = BFM contents of row9 col3.
- PRECHARGE_ALL with banks 2 and 6 open → exactly two dram_pre pulses (bank ids 2, 6); subsequent READ bank6 takes the closed-bank latency of 6.
- Hold cmd_req high 5 cycles past ack → cmd_ack stays 1 and no second operation; drop req → ack 0 next cycle.
- Assert rst during ACT → all outputs 0 next cycle; next access to the same bank activates again (no hit).

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: command encoding, scheduler states and default timing shared by dram_cmd_sched.
package dram_pkg;
  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_READ   = 2'b01;
  localparam logic [1:0] CMD_WRITE  = 2'b10;
  localparam logic [1:0] CMD_PREALL = 2'b11;
  localparam int DEF_BANKS      = 8;
  localparam int DEF_ROWS       = 128;
  localparam int DEF_COLS       = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_T_RP       = 2;
  localparam int DEF_T_RCD      = 3;
  localparam int DEF_T_CAS      = 2;
  typedef enum logic [2:0] {IDLE, PRE, ACT, ACCESS, ACK, PRE_ALL} sched_state_t;
endpackage

// File: rtl/dram_cmd_sched_if.sv
// dram_cmd_sched_if: upstream 4-phase command handshake plus the DRAM primitive bus.
interface dram_cmd_sched_if #(
  parameter int BANK_W     = 3,
  parameter int ROW_W      = 7,
  parameter int COL_W      = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_req;
  logic [1:0]            cmd;
  logic [BANK_W-1:0]     bank_id;
  logic [ROW_W-1:0]      row_id;
  logic [COL_W-1:0]      col_id;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  cmd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  dram_pre;
  logic                  dram_act;
  logic                  dram_buf_en;
  logic                  dram_buf_rw;
  logic [BANK_W-1:0]     dram_bank_id;
  logic [ROW_W-1:0]      dram_row_id;
  logic [COL_W-1:0]      dram_col_id;
  logic [DATA_WIDTH-1:0] dram_din;
  logic [DATA_WIDTH-1:0] dram_dout;
  modport sched (
    input  cmd_req, cmd, bank_id, row_id, col_id, wr_data, dram_dout,
    output cmd_ack, rd_data, dram_pre, dram_act, dram_buf_en, dram_buf_rw,
           dram_bank_id, dram_row_id, dram_col_id, dram_din
  );
  modport master (
    output cmd_req, cmd, bank_id, row_id, col_id, wr_data, dram_dout,
    input  cmd_ack, rd_data, dram_pre, dram_act, dram_buf_en, dram_buf_rw,
           dram_bank_id, dram_row_id, dram_col_id, dram_din
  );
endinterface

// File: rtl/dram_open_row_table.sv
// dram_open_row_table: per-bank open-row registers with hit/closed lookup and update/clear ports.
module dram_open_row_table #(
  parameter  int NUM_OF_BANKS = 8,
  parameter  int ROW_W        = 7,
  localparam int BANK_W       = $clog2(NUM_OF_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BANK_W-1:0] i_lk_bank,
  input  logic [ROW_W-1:0]  i_lk_row,
  output logic              o_hit,
  output logic              o_closed,
  input  logic              i_upd,
  input  logic              i_clr,
  input  logic              i_clr_all,
  input  logic [BANK_W-1:0] i_bank,
  input  logic [ROW_W-1:0]  i_row
);
  logic [NUM_OF_BANKS-1:0] r_valid;
  logic [ROW_W-1:0]        r_row [NUM_OF_BANKS];
  assign o_closed = !r_valid[i_lk_bank];
  assign o_hit    = r_valid[i_lk_bank] && r_row[i_lk_bank] == i_lk_row;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) r_row[i] <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid[i_bank] <= 1'b0;
    end else if (i_upd) begin
      r_valid[i_bank] <= 1'b1;
      r_row[i_bank]   <= i_row;
    end
  end
endmodule

// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: open-page scheduler turning 4-phase requests into precharge/activate/access primitives.
// Optional macro DRAM_SCHED_STATS_EN adds saturating stat_hits/stat_misses/stat_closed counters.
module dram_cmd_sched
  import dram_pkg::*;
#(
  parameter  int NUM_OF_BANKS = DEF_BANKS,
  parameter  int NUM_OF_ROWS  = DEF_ROWS,
  parameter  int NUM_OF_COLS  = DEF_COLS,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int T_RP         = DEF_T_RP,
  parameter  int T_RCD        = DEF_T_RCD,
  parameter  int T_CAS        = DEF_T_CAS,
  localparam int BANK_W       = $clog2(NUM_OF_BANKS),
  localparam int ROW_W        = $clog2(NUM_OF_ROWS),
  localparam int COL_W        = $clog2(NUM_OF_COLS)
) (
  input  logic clk,
  input  logic rst,
  dram_cmd_sched_if.sched bus
`ifdef DRAM_SCHED_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
  output logic [15:0] stat_closed
`endif
);
  localparam int TW = 8;
  sched_state_t          r_state, w_state;
  logic [TW-1:0]         r_timer, w_timer;
  logic                  r_entry, w_entry;
  logic [1:0]            r_cmd, w_cmd;
  logic [BANK_W-1:0]     r_bank, w_bank, w_lk_bank;
  logic [ROW_W-1:0]      r_row, w_row;
  logic [COL_W-1:0]      r_col, w_col;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata, r_rdata, w_rdata;
  logic                  w_hit, w_closed, w_upd, w_clr, w_clr_all;
  // the lookup port follows the incoming request in IDLE and the PRE_ALL sweep otherwise
  assign w_lk_bank = r_state == IDLE ? bus.bank_id : r_bank;
  dram_open_row_table #(.NUM_OF_BANKS(NUM_OF_BANKS), .ROW_W(ROW_W)) u_tbl (
    .clk(clk), .rst(rst),
    .i_lk_bank(w_lk_bank), .i_lk_row(bus.row_id), .o_hit(w_hit), .o_closed(w_closed),
    .i_upd(w_upd), .i_clr(w_clr), .i_clr_all(w_clr_all), .i_bank(r_bank), .i_row(r_row)
  );
  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_entry   = 1'b0;
    w_cmd     = r_cmd;
    w_bank    = r_bank;
    w_row     = r_row;
    w_col     = r_col;
    w_wdata   = r_wdata;
    w_rdata   = r_rdata;
    w_upd     = 1'b0;
    w_clr     = 1'b0;
    w_clr_all = 1'b0;
    case (r_state)
      IDLE: if (bus.cmd_req) begin
        w_cmd   = bus.cmd;
        w_bank  = bus.bank_id;
        w_row   = bus.row_id;
        w_col   = bus.col_id;
        w_wdata = bus.wr_data;
        w_entry = 1'b1;
        if (bus.cmd == CMD_NOP) w_state = ACK;
        else if (bus.cmd == CMD_PREALL) begin
          w_state = PRE_ALL;
          w_bank  = '0;
          w_timer = TW'(T_RP - 1);
        end else begin
          w_state = w_hit ? ACCESS : w_closed ? ACT : PRE;
          w_timer = w_hit ? TW'(T_CAS - 1) : w_closed ? TW'(T_RCD - 1) : TW'(T_RP - 1);
        end
      end
      PRE: if (r_timer == '0) begin
        w_clr   = 1'b1;
        w_state = ACT;
        w_timer = TW'(T_RCD - 1);
        w_entry = 1'b1;
      end else w_timer = r_timer - 1'b1;
      ACT: if (r_timer == '0) begin
        w_upd   = 1'b1;
        w_state = ACCESS;
        w_timer = TW'(T_CAS - 1);
      end else w_timer = r_timer - 1'b1;
      ACCESS: if (r_timer == '0) begin
        w_rdata = r_cmd == CMD_READ ? bus.dram_dout : r_rdata;
        w_state = ACK;
      end else w_timer = r_timer - 1'b1;
      ACK: w_state = bus.cmd_req ? ACK : IDLE;
      // closed banks advance after one cycle; open ones hold for a full precharge window
      PRE_ALL: if (w_closed || r_timer == '0) begin
        w_entry = 1'b1;
        w_timer = TW'(T_RP - 1);
        if (r_bank == BANK_W'(NUM_OF_BANKS - 1)) begin
          w_clr_all = 1'b1;
          w_state   = ACK;
        end else w_bank = r_bank + 1'b1;
      end else w_timer = r_timer - 1'b1;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_entry <= 1'b0;
      r_cmd   <= CMD_NOP;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_entry <= w_entry;
      r_cmd   <= w_cmd;
      r_bank  <= w_bank;
      r_row   <= w_row;
      r_col   <= w_col;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
    end
  end
  assign bus.cmd_ack      = r_state == ACK;
  assign bus.rd_data      = r_rdata;
  assign bus.dram_pre     = r_entry && (r_state == PRE || (r_state == PRE_ALL && !w_closed));
  assign bus.dram_act     = r_entry && r_state == ACT;
  assign bus.dram_buf_en  = r_state == ACCESS;
  assign bus.dram_buf_rw  = r_state == ACCESS && r_cmd == CMD_WRITE;
  assign bus.dram_bank_id = r_bank;
  assign bus.dram_row_id  = r_row;
  assign bus.dram_col_id  = r_col;
  assign bus.dram_din     = r_wdata;
`ifdef DRAM_SCHED_STATS_EN
  logic w_acc_rw;
  assign w_acc_rw = r_state == IDLE && bus.cmd_req && (bus.cmd == CMD_READ || bus.cmd == CMD_WRITE);
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_closed <= '0;
    end else if (w_acc_rw) begin
      if (w_hit && !(&stat_hits)) stat_hits <= stat_hits + 1'b1;
      if (w_closed && !(&stat_closed)) stat_closed <= stat_closed + 1'b1;
      if (!w_hit && !w_closed && !(&stat_misses)) stat_misses <= stat_misses + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb_dram_cmd_sched: directed requests against a row-buffer DRAM model with a queue-based scoreboard.
module tb_dram_cmd_sched;
  import dram_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dram_cmd_sched_if #(.BANK_W(3), .ROW_W(7), .COL_W(3), .DATA_WIDTH(8)) bus ();
`ifdef DRAM_SCHED_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_closed;
  dram_cmd_sched dut (.clk(clk), .rst(rst), .bus(bus),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_closed(stat_closed));
`else
  dram_cmd_sched dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  logic [7:0] mem [8][128][8];
  logic [7:0] rbuf [8][8];
  logic [6:0] brow [8];
  bit inited;
  assign bus.dram_dout = rbuf[bus.dram_bank_id][bus.dram_col_id];
  always @(posedge clk) begin
    if (!inited) begin
      for (int b = 0; b < 8; b++)
        for (int r = 0; r < 128; r++)
          for (int c = 0; c < 8; c++) mem[b][r][c] <= 8'(b * 37 + r * 5 + c);
      for (int b = 0; b < 8; b++) begin
        brow[b] <= '0;
        for (int c = 0; c < 8; c++) rbuf[b][c] <= '0;
      end
      inited <= 1'b1;
    end else begin
      if (bus.dram_pre)
        for (int c = 0; c < 8; c++) mem[bus.dram_bank_id][brow[bus.dram_bank_id]][c] <= rbuf[bus.dram_bank_id][c];
      if (bus.dram_act) begin
        for (int c = 0; c < 8; c++) rbuf[bus.dram_bank_id][c] <= mem[bus.dram_bank_id][bus.dram_row_id][c];
        brow[bus.dram_bank_id] <= bus.dram_row_id;
      end
      if (bus.dram_buf_en && bus.dram_buf_rw) rbuf[bus.dram_bank_id][bus.dram_col_id] <= bus.dram_din;
    end
  end
  typedef struct {
    string nm;
    int lat, npre, nact, nw, nr, mask, rd;
    bit crd;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0, start = 0, n_pre = 0, n_act = 0, n_wacc = 0, n_racc = 0, mask = 0, bad_ord = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cmd_req && !prev_req) begin
        start = cyc; n_pre = 0; n_act = 0; n_wacc = 0; n_racc = 0; mask = 0; bad_ord = 0;
      end
      if (bus.dram_pre) begin
        n_pre++;
        mask = mask | (1 << bus.dram_bank_id);
        if (n_act + n_wacc + n_racc != 0) bad_ord++;
      end
      if (bus.dram_act) begin
        n_act++;
        if (n_wacc + n_racc != 0) bad_ord++;
      end
      if (bus.dram_buf_en) begin
        if (bus.dram_buf_rw) n_wacc++;
        else n_racc++;
      end
      if (bus.cmd_ack && !prev_ack) begin
        chk("sb_has_entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({e.nm, ".latency"}, cyc - start + 1, e.lat);
          chk({e.nm, ".n_pre"}, n_pre, e.npre);
          chk({e.nm, ".n_act"}, n_act, e.nact);
          chk({e.nm, ".n_wr_acc"}, n_wacc, e.nw);
          chk({e.nm, ".n_rd_acc"}, n_racc, e.nr);
          chk({e.nm, ".pre_banks"}, mask, e.mask);
          chk({e.nm, ".order"}, bad_ord, 0);
          if (e.crd) chk({e.nm, ".rd_data"}, int'(bus.rd_data), e.rd);
        end
      end
      prev_req = bus.cmd_req;
      prev_ack = bus.cmd_ack;
    end
  end
  task automatic chk_quiet(input string nm);
    chk({nm, ".ack"}, int'(bus.cmd_ack), 0);
    chk({nm, ".pre"}, int'(bus.dram_pre), 0);
    chk({nm, ".act"}, int'(bus.dram_act), 0);
    chk({nm, ".buf_en"}, int'(bus.dram_buf_en), 0);
    chk({nm, ".buf_rw"}, int'(bus.dram_buf_rw), 0);
    chk({nm, ".bank_id"}, int'(bus.dram_bank_id), 0);
    chk({nm, ".row_id"}, int'(bus.dram_row_id), 0);
    chk({nm, ".rd_data"}, int'(bus.rd_data), 0);
  endtask
  task automatic op(input string nm, input logic [1:0] c, input int b, input int r, input int co,
                    input logic [7:0] wd, input int lat, input int np, input int na, input int nw,
                    input int nr, input int msk, input logic [7:0] erd, input bit crd, input int hold);
    exp_t e;
    int n, tot;
    e.nm = nm; e.lat = lat; e.npre = np; e.nact = na; e.nw = nw; e.nr = nr;
    e.mask = msk; e.rd = int'(erd); e.crd = crd;
    @(negedge clk);
    sb.push_back(e);
    bus.cmd_req = 1'b1; bus.cmd = c; bus.bank_id = 3'(b); bus.row_id = 7'(r);
    bus.col_id = 3'(co); bus.wr_data = wd;
    @(negedge clk);
    bus.cmd = ~c; bus.bank_id = ~3'(b); bus.row_id = ~7'(r); bus.col_id = ~3'(co); bus.wr_data = ~wd;
    n = 0;
    while (!bus.cmd_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".ack_seen"}, int'(bus.cmd_ack), 1);
    tot = n_pre + n_act + n_wacc + n_racc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, ".hold_ack"}, int'(bus.cmd_ack), 1);
    end
    if (hold > 0) chk({nm, ".hold_quiet"}, n_pre + n_act + n_wacc + n_racc, tot);
    @(negedge clk);
    bus.cmd_req = 1'b0;
    @(negedge clk);
    chk({nm, ".ack_drop"}, int'(bus.cmd_ack), 0);
  endtask
  initial begin
    int n;
    bus.cmd_req = 1'b0; bus.cmd = CMD_NOP; bus.bank_id = '0; bus.row_id = '0;
    bus.col_id = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    op("wr_b2r5_closed", CMD_WRITE,  2, 5, 3, 8'hA5, 6,  0, 1, 2, 0, 0,     8'h00, 1'b0, 0);
    op("rd_b2r5_hit",    CMD_READ,   2, 5, 3, 8'h00, 3,  0, 0, 0, 2, 0,     8'hA5, 1'b1, 0);
    op("rd_b2r9_miss",   CMD_READ,   2, 9, 3, 8'h00, 8,  1, 1, 0, 2, 8'h04, 8'h7A, 1'b1, 0);
    op("wr_b6r1_closed", CMD_WRITE,  6, 1, 0, 8'h3C, 6,  0, 1, 2, 0, 0,     8'h00, 1'b0, 0);
    op("prall",          CMD_PREALL, 0, 0, 0, 8'h00, 11, 2, 0, 0, 0, 8'h44, 8'h00, 1'b0, 0);
    op("rd_b6r1_closed", CMD_READ,   6, 1, 0, 8'h00, 6,  0, 1, 0, 2, 0,     8'h3C, 1'b1, 0);
    op("rd_b2r5_wrback", CMD_READ,   2, 5, 3, 8'h00, 6,  0, 1, 0, 2, 0,     8'hA5, 1'b1, 0);
    op("rd_b6r1_hold",   CMD_READ,   6, 1, 0, 8'h00, 3,  0, 0, 0, 2, 0,     8'h3C, 1'b1, 5);
    op("nop",            CMD_NOP,    3, 3, 3, 8'h00, 1,  0, 0, 0, 0, 0,     8'h3C, 1'b1, 0);
    @(negedge clk);
    bus.cmd_req = 1'b1; bus.cmd = CMD_READ; bus.bank_id = 3'd4; bus.row_id = 7'd2; bus.col_id = 3'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.act_seen", n_act, 1);
    rst = 1'b1;
    bus.cmd_req = 1'b0;
    @(negedge clk);
    chk_quiet("rst_mid");
    rst = 1'b0;
    op("rd_b4r2_after_rst", CMD_READ, 4, 2, 1, 8'h00, 6, 0, 1, 0, 2, 0, 8'h9F, 1'b1, 0);
    op("rd_b6r1_forgot",    CMD_READ, 6, 1, 0, 8'h00, 6, 0, 1, 0, 2, 0, 8'h3C, 1'b1, 0);
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
